// File: rtl/edge_ptr_div_pkg.sv
// Shared widths, FSM encoding and iteration count for the edge-pointer divider.
package edge_ptr_div_pkg;

    localparam int PKG_DIVIDEND_W = 30;
    localparam int PKG_DIVISOR_W  = 14;
    localparam int PKG_REM_W      = PKG_DIVISOR_W + 1;

    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] CNT_LAST = 5'd29;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/edge_ptr_div_step.sv
// One restoring shift-subtract step: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module edge_ptr_div_step
    import edge_ptr_div_pkg::*;
#(
    parameter int DIVISOR_W = PKG_DIVISOR_W,
    parameter int REM_W     = PKG_REM_W
) (
    input  logic [REM_W-1:0]     i_pr,
    input  logic                 i_bit,
    input  logic [DIVISOR_W-1:0] i_divisor,
    output logic [REM_W-1:0]     o_pr,
    output logic                 o_qbit
);

    logic [REM_W:0] w_shift;
    logic [REM_W:0] w_div_ext;

    assign w_shift   = {i_pr, i_bit};
    assign w_div_ext = {{(REM_W + 1 - DIVISOR_W){1'b0}}, i_divisor};

    // Compare the shifted remainder against the divisor and restore on miss.
    always_comb begin
        o_qbit = (w_shift >= w_div_ext);
        o_pr   = REM_W'(w_shift);
        if (o_qbit) begin
            o_pr = REM_W'(w_shift - w_div_ext);
        end
    end

endmodule

// File: rtl/edge_ptr_div_30s_14ns_seq.sv
// Sequential signed-by-unsigned divider recovering index and intra-stride
// position from a flat edge-pointer offset. Magnitude division runs MSB first
// over 30 cycles, then the dividend sign is applied to both results.
module edge_ptr_div_30s_14ns_seq
    import edge_ptr_div_pkg::*;
#(
    parameter int DIVIDEND_W = PKG_DIVIDEND_W,
    parameter int DIVISOR_W  = PKG_DIVISOR_W,
    parameter int REM_W      = PKG_REM_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [REM_W-1:0]      remainder,
    output logic                  div_by_zero
);

    state_t                r_state;
    logic [DIVIDEND_W-1:0] r_dq;
    logic [REM_W-1:0]      r_pr;
    logic [DIVISOR_W-1:0]  r_div;
    logic                  r_sign;
    logic                  r_dbz;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [DIVIDEND_W-1:0] r_quot;
    logic [REM_W-1:0]      r_rem;
    logic                  r_dbz_out;

    logic [DIVIDEND_W-1:0] w_abs;
    logic [REM_W-1:0]      w_pr_next;
    logic                  w_qbit;

    assign w_abs = dividend[DIVIDEND_W-1] ? -dividend : dividend;

    edge_ptr_div_step #(
        .DIVISOR_W (DIVISOR_W),
        .REM_W     (REM_W)
    ) u_step (
        .i_pr      (r_pr),
        .i_bit     (r_dq[DIVIDEND_W-1]),
        .i_divisor (r_div),
        .o_pr      (w_pr_next),
        .o_qbit    (w_qbit)
    );

    // Control FSM with datapath registers and registered handshake outputs;
    // nothing moves while ce is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_dq        <= '0;
            r_pr        <= '0;
            r_div       <= '0;
            r_sign      <= 1'b0;
            r_dbz       <= 1'b0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_quot      <= '0;
            r_rem       <= '0;
            r_dbz_out   <= 1'b0;
        end else if (ce) begin
            case (r_state)
                IDLE: begin
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_dq       <= w_abs;
                        r_div      <= divisor;
                        r_sign     <= dividend[DIVIDEND_W-1];
                        r_pr       <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        if (divisor == '0) begin
                            r_dbz   <= 1'b1;
                            r_state <= FIX;
                        end else begin
                            r_dbz   <= 1'b0;
                            r_state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    r_dq  <= {r_dq[DIVIDEND_W-2:0], w_qbit};
                    r_pr  <= w_pr_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    if (r_dbz) begin
                        r_quot    <= '0;
                        r_rem     <= '0;
                        r_dbz_out <= 1'b1;
                    end else begin
                        r_quot    <= r_sign ? -r_dq : r_dq;
                        r_rem     <= r_sign ? -r_pr : r_pr;
                        r_dbz_out <= 1'b0;
                    end
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz_out;

endmodule
